// File: rtl/tiny_nn_replay_pkg.sv
// tiny_nn_replay_pkg
// Shared types and constants for the tiny-nn stimulus-replay engine.
//   replay_state_e : engine state (idle, replaying stimulus, draining responses)
//   CRC_POLY/INIT  : CRC-16-CCITT parameters for the optional response signature
//   crc16_bit      : one MSB-first CRC shift step

package tiny_nn_replay_pkg;

  typedef enum logic [1:0] {
    ReplayIdle,
    ReplayPlay,
    ReplayDrain
  } replay_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Shift one data bit into the CRC, most significant data bit first.
  function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/tiny_nn_replay_if.sv
// tiny_nn_replay_if
// Bundles the stimulus load handshake and the tiny-nn core data port.
// Signal names are written from the replay engine's point of view.
//   load_valid_i  : stimulus word valid (host -> engine)
//   load_data_i   : stimulus word, IN_W bits (host -> engine)
//   load_ready_o  : stimulus buffer accepts a word (engine -> host)
//   dut_data_o    : word driven to the core data_i, IN_W bits (engine -> core)
//   dut_data_i    : core data_o sampled each cycle, OUT_W bits (core -> engine)
//   dut_idle_i    : core FSM is in its idle state (core -> engine)
// Modports: slave = replay engine, master = host/core side.

interface tiny_nn_replay_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) ();

  logic             load_valid_i;
  logic [IN_W-1:0]  load_data_i;
  logic             load_ready_o;
  logic [IN_W-1:0]  dut_data_o;
  logic [OUT_W-1:0] dut_data_i;
  logic             dut_idle_i;

  modport slave (
    input  load_valid_i,
    input  load_data_i,
    output load_ready_o,
    output dut_data_o,
    input  dut_data_i,
    input  dut_idle_i
  );

  modport master (
    output load_valid_i,
    output load_data_i,
    input  load_ready_o,
    input  dut_data_o,
    output dut_data_i,
    output dut_idle_i
  );

endinterface

// File: rtl/tiny_nn_replay_ram.sv
// tiny_nn_replay_ram
// Simple dual-port buffer: one synchronous write port and one registered
// read port with one cycle of latency. The read register resets to zero;
// the storage array itself is not reset.
//   clk_i, rst_i : clock, asynchronous active-high reset (read register only)
//   we_i         : write enable
//   waddr_i      : write address
//   wdata_i      : write data, W bits
//   raddr_i      : read address
//   rdata_o      : data at raddr_i as of the previous clock edge

module tiny_nn_replay_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // Storage array: plain write port, no reset so it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; a same-address write returns the old contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tiny_nn_replay.sv
// tiny_nn_replay
// Stimulus-replay and response-capture engine for the tiny-nn datapath.
// A host preloads stimulus words; on start they are streamed into the core
// one per clock while every core output byte is recorded. After the last
// word the engine keeps capturing until the core reports idle or
// IDLE_TIMEOUT drain cycles pass without idle.
// Optional feature: define TINY_NN_REPLAY_SIG_EN to add sig_o, a
// CRC-16-CCITT over every stored response.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   bus (slave)      : load handshake and core data port (see tiny_nn_replay_if)
//   clear_i          : empty both buffers (Idle only)
//   start_i          : begin a replay run (Idle only, needs >=1 word)
//   busy_o           : replay or drain in progress
//   done_o           : one-cycle pulse after a run ends
//   timeout_o        : sticky, last run gave up waiting for idle
//   overflow_o       : sticky, last run dropped responses
//   stim_count_o     : stimulus words loaded
//   resp_count_o     : responses stored
//   resp_rd_addr_i   : response read address
//   resp_rd_data_o   : response at address, one cycle latency
//   sig_o            : response CRC (TINY_NN_REPLAY_SIG_EN only)

module tiny_nn_replay
  import tiny_nn_replay_pkg::*;
#(
  parameter int IN_W         = 16,
  parameter int OUT_W        = 8,
  parameter int STIM_DEPTH   = 64,
  parameter int RESP_DEPTH   = 256,
  parameter int IDLE_TIMEOUT = 100
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  tiny_nn_replay_if.slave               bus,
  input  logic                          clear_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          timeout_o,
  output logic                          overflow_o,
  output logic [$clog2(STIM_DEPTH):0]   stim_count_o,
  output logic [$clog2(RESP_DEPTH):0]   resp_count_o,
  input  logic [$clog2(RESP_DEPTH)-1:0] resp_rd_addr_i,
  output logic [OUT_W-1:0]              resp_rd_data_o
`ifdef TINY_NN_REPLAY_SIG_EN
  ,
  output logic [15:0]                   sig_o
`endif
);

  localparam int SAW = $clog2(STIM_DEPTH);
  localparam int RAW = $clog2(RESP_DEPTH);
  localparam int TW  = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [SAW:0]   STIM_FULL = (SAW + 1)'(STIM_DEPTH);
  localparam logic [SAW:0]   STIM_ONE  = (SAW + 1)'(1);
  localparam logic [RAW:0]   RESP_FULL = (RAW + 1)'(RESP_DEPTH);
  localparam logic [RAW:0]   RESP_ONE  = (RAW + 1)'(1);
  localparam logic [TW-1:0]  TMO_LIMIT = TW'(IDLE_TIMEOUT);
  localparam logic [TW-1:0]  TMO_ONE   = TW'(1);
  localparam logic [SAW-1:0] IDX_ONE   = SAW'(1);

  replay_state_e  state_q, state_d;
  logic [SAW-1:0] idx_q, idx_d;
  logic [SAW:0]   stim_count_q, stim_count_d;
  logic [RAW:0]   resp_count_q, resp_count_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           done_q, done_d;
  logic           timeout_q, timeout_d;
  logic           overflow_q, overflow_d;

  logic           load_ready;
  logic           stim_we;
  logic           resp_we;
  logic           capture;
  logic [IN_W-1:0] stim_rdata;

`ifdef TINY_NN_REPLAY_SIG_EN
  logic [15:0]    sig_q, sig_d;
  logic [15:0]    crc_next;
`endif

  // Loads are only offered in Idle and while the stimulus buffer has room.
  assign load_ready = (state_q == ReplayIdle) && (stim_count_q < STIM_FULL);

  // Next-state logic for the whole engine. The stimulus read address is
  // idx_d so the registered RAM output lines up with idx_q during Play.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stim_count_d = stim_count_q;
    resp_count_d = resp_count_q;
    tmo_cnt_d    = tmo_cnt_q;
    done_d       = 1'b0;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;
    stim_we      = 1'b0;
    resp_we      = 1'b0;
    capture      = 1'b0;
`ifdef TINY_NN_REPLAY_SIG_EN
    sig_d        = sig_q;
    crc_next     = sig_q;
    for (int b = OUT_W - 1; b >= 0; b--) begin
      crc_next = crc16_bit(crc_next, bus.dut_data_i[b]);
    end
`endif

    unique case (state_q)
      ReplayIdle: begin
        if (clear_i) begin
          // Clear takes precedence over a same-cycle load or start.
          stim_count_d = '0;
          resp_count_d = '0;
        end else begin
          if (bus.load_valid_i && load_ready) begin
            stim_we      = 1'b1;
            stim_count_d = stim_count_q + STIM_ONE;
          end
          if (start_i && (stim_count_q != '0)) begin
            state_d      = ReplayPlay;
            idx_d        = '0;
            resp_count_d = '0;
            tmo_cnt_d    = '0;
            timeout_d    = 1'b0;
            overflow_d   = 1'b0;
`ifdef TINY_NN_REPLAY_SIG_EN
            sig_d        = CRC_INIT;
`endif
          end
        end
      end

      ReplayPlay: begin
        capture = 1'b1;
        if ({1'b0, idx_q} == (stim_count_q - STIM_ONE)) begin
          state_d = ReplayDrain;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      ReplayDrain: begin
        capture = 1'b1;
        if (bus.dut_idle_i) begin
          state_d = ReplayIdle;
          done_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_ONE;
          if ((tmo_cnt_q + TMO_ONE) == TMO_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = ReplayIdle;
            done_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = ReplayIdle;
      end
    endcase

    // Every Play/Drain cycle captures; a full response buffer drops the byte.
    if (capture) begin
      if (resp_count_q == RESP_FULL) begin
        overflow_d = 1'b1;
      end else begin
        resp_we      = 1'b1;
        resp_count_d = resp_count_q + RESP_ONE;
`ifdef TINY_NN_REPLAY_SIG_EN
        sig_d        = crc_next;
`endif
      end
    end
  end

  // All engine state registers; reset aborts any run without a done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ReplayIdle;
      idx_q        <= '0;
      stim_count_q <= '0;
      resp_count_q <= '0;
      tmo_cnt_q    <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef TINY_NN_REPLAY_SIG_EN
      sig_q        <= CRC_INIT;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stim_count_q <= stim_count_d;
      resp_count_q <= resp_count_d;
      tmo_cnt_q    <= tmo_cnt_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
`ifdef TINY_NN_REPLAY_SIG_EN
      sig_q        <= sig_d;
`endif
    end
  end

  tiny_nn_replay_ram #(
    .W     (IN_W),
    .DEPTH (STIM_DEPTH)
  ) u_stim_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (stim_we),
    .waddr_i (stim_count_q[SAW-1:0]),
    .wdata_i (bus.load_data_i),
    .raddr_i (idx_d),
    .rdata_o (stim_rdata)
  );

  tiny_nn_replay_ram #(
    .W     (OUT_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (resp_we),
    .waddr_i (resp_count_q[RAW-1:0]),
    .wdata_i (bus.dut_data_i),
    .raddr_i (resp_rd_addr_i),
    .rdata_o (resp_rd_data_o)
  );

  // The core sees stimulus only during Play; zero otherwise.
  assign bus.dut_data_o   = (state_q == ReplayPlay) ? stim_rdata : '0;
  assign bus.load_ready_o = load_ready;

  assign busy_o       = (state_q != ReplayIdle);
  assign done_o       = done_q;
  assign timeout_o    = timeout_q;
  assign overflow_o   = overflow_q;
  assign stim_count_o = stim_count_q;
  assign resp_count_o = resp_count_q;
`ifdef TINY_NN_REPLAY_SIG_EN
  assign sig_o        = sig_q;
`endif

endmodule

// File: tb/tb_tiny_nn_replay.sv
// tb_tiny_nn_replay
// Self-checking bench for tiny_nn_replay. Instance A uses default
// parameters; instance B uses a 4-entry response buffer and a short
// timeout. A small core model echoes the low byte of the driven word and
// raises idle a programmable number of cycles into the drain phase.

module tb_tiny_nn_replay;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tiny_nn_replay_if #(.IN_W(16), .OUT_W(8)) if_a ();
  tiny_nn_replay_if #(.IN_W(16), .OUT_W(8)) if_b ();

  logic       clear_a, start_a, busy_a, done_a, timeout_a, overflow_a;
  logic [6:0] stim_count_a;
  logic [8:0] resp_count_a;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_data_a;

  logic       clear_b, start_b, busy_b, done_b, timeout_b, overflow_b;
  logic [3:0] stim_count_b;
  logic [2:0] resp_count_b;
  logic [1:0] rd_addr_b;
  logic [7:0] rd_data_b;

`ifdef TINY_NN_REPLAY_SIG_EN
  logic [15:0] sig_a, sig_b;
`endif

  tiny_nn_replay u_dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (if_a),
    .clear_i        (clear_a),
    .start_i        (start_a),
    .busy_o         (busy_a),
    .done_o         (done_a),
    .timeout_o      (timeout_a),
    .overflow_o     (overflow_a),
    .stim_count_o   (stim_count_a),
    .resp_count_o   (resp_count_a),
    .resp_rd_addr_i (rd_addr_a),
    .resp_rd_data_o (rd_data_a)
`ifdef TINY_NN_REPLAY_SIG_EN
    ,
    .sig_o          (sig_a)
`endif
  );

  tiny_nn_replay #(
    .STIM_DEPTH   (8),
    .RESP_DEPTH   (4),
    .IDLE_TIMEOUT (3)
  ) u_dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (if_b),
    .clear_i        (clear_b),
    .start_i        (start_b),
    .busy_o         (busy_b),
    .done_o         (done_b),
    .timeout_o      (timeout_b),
    .overflow_o     (overflow_b),
    .stim_count_o   (stim_count_b),
    .resp_count_o   (resp_count_b),
    .resp_rd_addr_i (rd_addr_b),
    .resp_rd_data_o (rd_data_b)
`ifdef TINY_NN_REPLAY_SIG_EN
    ,
    .sig_o          (sig_b)
`endif
  );

  // Core model for A: echo low byte while stimulus is nonzero, otherwise
  // return drain_resp_a; idle rises once run_cyc_a reaches idle_at_a.
  int         run_cyc_a = 0;
  int         idle_at_a;
  logic       idle_en_a;
  logic [7:0] drain_resp_a;
  logic       idle_b;

  always @(posedge clk) run_cyc_a <= busy_a ? run_cyc_a + 1 : 0;

  assign if_a.dut_idle_i = idle_en_a && (run_cyc_a >= idle_at_a);
  assign if_a.dut_data_i = (if_a.dut_data_o != 16'h0000) ? if_a.dut_data_o[7:0] : drain_resp_a;
  assign if_b.dut_idle_i = idle_b;
  assign if_b.dut_data_i = if_b.dut_data_o[7:0];

  typedef struct {
    int              n;
    logic [3:0][15:0] words;
    logic            idle_en;
    int              idle_delay;
    int              exp_busy;
    int              exp_resp;
    logic            exp_timeout;
  } scen_t;

  scen_t scen [4];

  int vec_count  = 0;
  int miss_count = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearA();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
  endtask

  task automatic loadWordA(input logic [15:0] w);
    if_a.load_valid_i = 1'b1;
    if_a.load_data_i  = w;
    tick();
    if_a.load_valid_i = 1'b0;
  endtask

  task automatic loadWordB(input logic [15:0] w);
    if_b.load_valid_i = 1'b1;
    if_b.load_data_i  = w;
    tick();
    if_b.load_valid_i = 1'b0;
  endtask

  // Run one table scenario on instance A and check the stream, counts,
  // flags and the first few stored responses.
  task automatic applyStimulus(input int s);
    int          busy_cnt;
    logic        seen_end;
    logic [15:0] exp_word;
    logic [7:0]  exp_byte;
    int          rd_n;
    clearA();
    for (int k = 0; k < scen[s].n; k++) loadWordA(scen[s].words[k]);
    checkOutput("stim_count_loaded", 32'(stim_count_a), scen[s].n);
    idle_en_a    = scen[s].idle_en;
    idle_at_a    = scen[s].n + scen[s].idle_delay;
    drain_resp_a = 8'h00;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    busy_cnt = 0;
    seen_end = 1'b0;
    for (int c = 0; c < 1000 && !seen_end; c++) begin
      @(negedge clk);
      if (busy_a) begin
        exp_word = (busy_cnt < scen[s].n) ? scen[s].words[busy_cnt] : 16'h0000;
        checkOutput("dut_data_stream", 32'(if_a.dut_data_o), 32'(exp_word));
        busy_cnt++;
      end else begin
        seen_end = 1'b1;
      end
    end
    checkOutput("run_terminated", 32'(seen_end), 1);
    checkOutput("done_pulse", 32'(done_a), 1);
    checkOutput("busy_cycles", busy_cnt, scen[s].exp_busy);
    checkOutput("resp_count", 32'(resp_count_a), scen[s].exp_resp);
    checkOutput("timeout_flag", 32'(timeout_a), 32'(scen[s].exp_timeout));
    checkOutput("overflow_flag", 32'(overflow_a), 0);
    @(negedge clk);
    checkOutput("done_single_cycle", 32'(done_a), 0);
    rd_n = (scen[s].exp_resp < 6) ? scen[s].exp_resp : 6;
    for (int k = 0; k < rd_n; k++) begin
      rd_addr_a = 8'(k);
      @(posedge clk);
      @(negedge clk);
      exp_word = (k < scen[s].n) ? scen[s].words[k] : 16'h0000;
      exp_byte = exp_word[7:0];
      checkOutput("resp_readback", 32'(rd_data_a), 32'(exp_byte));
    end
  endtask

  // Start instance B and check the end-of-run state; B always overflows.
  task automatic runB(input logic idle_val, input int exp_busy, input int exp_resp, input logic exp_tmo);
    int   busy_cnt;
    logic seen_end;
    idle_b  = idle_val;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    busy_cnt = 0;
    seen_end = 1'b0;
    for (int c = 0; c < 200 && !seen_end; c++) begin
      @(negedge clk);
      if (busy_b) busy_cnt++;
      else seen_end = 1'b1;
    end
    checkOutput("b_run_terminated", 32'(seen_end), 1);
    checkOutput("b_done_pulse", 32'(done_b), 1);
    checkOutput("b_busy_cycles", busy_cnt, exp_busy);
    checkOutput("b_resp_count", 32'(resp_count_b), exp_resp);
    checkOutput("b_overflow", 32'(overflow_b), 1);
    checkOutput("b_timeout", 32'(timeout_b), 32'(exp_tmo));
    rd_addr_b = 2'd3;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b_resp_readback3", 32'(rd_data_b), 32'h04);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   busy_cnt;
    logic seen_end;
    logic done_seen;

    rst = 1'b1;
    clear_a = 1'b0; start_a = 1'b0; rd_addr_a = '0;
    clear_b = 1'b0; start_b = 1'b0; rd_addr_b = '0;
    if_a.load_valid_i = 1'b0; if_a.load_data_i = '0;
    if_b.load_valid_i = 1'b0; if_b.load_data_i = '0;
    idle_en_a = 1'b0; idle_at_a = 0; drain_resp_a = 8'h00; idle_b = 1'b1;

    scen[0] = '{3, {16'h0000, 16'h0001, 16'hABCD, 16'h1234}, 1'b1, 1, 5, 5, 1'b0};
    scen[1] = '{2, {16'h0000, 16'h0000, 16'h0055, 16'h00AA}, 1'b0, 0, 102, 102, 1'b1};
    scen[2] = '{1, {16'h0000, 16'h0000, 16'h0000, 16'h007E}, 1'b1, 0, 2, 2, 1'b0};
    scen[3] = '{4, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 3, 8, 8, 1'b0};

    // Reset values, sampled while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_dut_data", 32'(if_a.dut_data_o), 0);
    checkOutput("rst_busy", 32'(busy_a), 0);
    checkOutput("rst_done", 32'(done_a), 0);
    checkOutput("rst_timeout", 32'(timeout_a), 0);
    checkOutput("rst_overflow", 32'(overflow_a), 0);
    checkOutput("rst_stim_count", 32'(stim_count_a), 0);
    checkOutput("rst_resp_count", 32'(resp_count_a), 0);
    checkOutput("rst_resp_rd_data", 32'(rd_data_a), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(if_a.load_ready_o), 1);
    checkOutput("post_rst_busy", 32'(busy_a), 0);

    // Clear beats a same-cycle load.
    loadWordA(16'h5555);
    if_a.load_valid_i = 1'b1;
    if_a.load_data_i  = 16'h6666;
    clear_a = 1'b1;
    tick();
    if_a.load_valid_i = 1'b0;
    clear_a = 1'b0;
    checkOutput("clear_wins_over_load", 32'(stim_count_a), 0);

    $display("[TB] table-driven replay scenarios");
    for (int s = 0; s < 4; s++) applyStimulus(s);

    $display("[TB] stimulus buffer fill and empty start");
    clearA();
    for (int k = 0; k < 64; k++) begin
      if (k == 63) checkOutput("ready_before_last", 32'(if_a.load_ready_o), 1);
      loadWordA(16'(k + 1));
    end
    checkOutput("ready_when_full", 32'(if_a.load_ready_o), 0);
    checkOutput("stim_count_full", 32'(stim_count_a), 64);
    loadWordA(16'hDEAD);
    checkOutput("stim_count_65th", 32'(stim_count_a), 64);
    clearA();
    checkOutput("ready_after_clear", 32'(if_a.load_ready_o), 1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    @(negedge clk);
    checkOutput("busy_empty_start", 32'(busy_a), 0);
    @(negedge clk);
    checkOutput("done_empty_start", 32'(done_a), 0);

    $display("[TB] response overflow on small instance");
    for (int k = 0; k < 6; k++) loadWordB(16'(((k + 1) << 8) | (k + 1)));
    checkOutput("b_stim_count", 32'(stim_count_b), 6);
    runB(1'b1, 7, 4, 1'b0);
    runB(1'b0, 9, 4, 1'b1);

`ifdef TINY_NN_REPLAY_SIG_EN
    $display("[TB] response signature");
    clearA();
    for (int k = 0; k < 8; k++) loadWordA(16'(8'h31 + k));
    idle_en_a    = 1'b1;
    idle_at_a    = 8;
    drain_resp_a = 8'h39;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    seen_end = 1'b0;
    for (int c = 0; c < 100 && !seen_end; c++) begin
      @(negedge clk);
      if (!busy_a) seen_end = 1'b1;
    end
    checkOutput("sig_run_terminated", 32'(seen_end), 1);
    checkOutput("sig_done", 32'(done_a), 1);
    checkOutput("sig_resp_count", 32'(resp_count_a), 9);
    checkOutput("sig_value", 32'(sig_a), 32'h29B1);
    drain_resp_a = 8'h00;
`endif

    $display("[TB] reset during replay");
    clearA();
    loadWordA(16'h0A01);
    loadWordA(16'h0B02);
    loadWordA(16'h0C03);
    loadWordA(16'h0D04);
    idle_en_a = 1'b1;
    idle_at_a = 4;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_run_idx2_data", 32'(if_a.dut_data_o), 32'h0C03);
    rst = 1'b1;
    #1;
    checkOutput("mid_run_rst_dut_data", 32'(if_a.dut_data_o), 0);
    checkOutput("mid_run_rst_busy", 32'(busy_a), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    done_seen = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done_a) done_seen = 1'b1;
      if (busy_a) busy_cnt++;
    end
    checkOutput("mid_run_no_done", 32'(done_seen), 0);
    checkOutput("mid_run_stays_idle", busy_cnt, 0);
    checkOutput("mid_run_stim_count", 32'(stim_count_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/tiny_nn_replay.md
# tiny_nn_replay

Synthesisable stimulus-replay and response-capture engine for the tiny-nn datapath. It sits between a host or load port and the `tiny_nn_top` data interface. It streams a preloaded sequence of input words into the core one per clock and records every output byte. After the sequence it keeps capturing until the core reports idle or a programmable timeout expires. It is generalised over data widths, buffer depths and timeout, and it carries an optional response signature.

## Interface
Parameters:
- `IN_W`, 16, width of words driven into the core
- `OUT_W`, 8, width of core output sampled each cycle
- `STIM_DEPTH`, 64, stimulus buffer entries (power of two)
- `RESP_DEPTH`, 256, response buffer entries (power of two)
- `IDLE_TIMEOUT`, 100, drain cycles without idle before giving up (≥1)

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous active-high reset
- `load_valid_i`  in  1  stimulus word valid
- `load_data_i`  in  IN_W  stimulus word
- `load_ready_o`  out  1  stimulus buffer accepts a word
- `clear_i`  in  1  empty both buffers (honoured in Idle only)
- `start_i`  in  1  begin replay
- `dut_data_o`  out  IN_W  word driven to core `data_i`
- `dut_data_i`  in  OUT_W  core `data_o`
- `dut_idle_i`  in  1  core FSM in its idle state
- `busy_o`  out  1  replay or drain in progress
- `done_o`  out  1  one-cycle pulse at run end
- `timeout_o`  out  1  sticky: last run hit `IDLE_TIMEOUT`
- `overflow_o`  out  1  sticky: responses dropped, buffer full
- `stim_count_o`  out  $clog2(STIM_DEPTH)+1  words loaded
- `resp_count_o`  out  $clog2(RESP_DEPTH)+1  responses captured
- `resp_rd_addr_i`  in  $clog2(RESP_DEPTH)  response read address
- `resp_rd_data_o`  out  OUT_W  response at address, registered, 1-cycle latency

## Operation
- States: Idle, Play, Drain.
- Idle:
  - `load_ready_o` = (stim_count < STIM_DEPTH). A load is accepted when valid && ready; it writes at `stim_count` and increments it.
  - `clear_i` zeroes `stim_count` and `resp_count`. If `clear_i` and a load happen in the same cycle, clear wins.
  - `start_i` with `stim_count` > 0: zero `resp_count`, clear `timeout_o`/`overflow_o`, go to Play with index 0.
  - `start_i` with `stim_count` == 0 is ignored.
- Play:
  - `dut_data_o` = stim[idx]. Each cycle, `dut_data_i` is captured, then idx increments.
  - After the cycle with idx = stim_count−1, go to Drain.
- Drain:
  - `dut_data_o` = 0. Each cycle, `dut_data_i` is captured.
  - If `dut_idle_i` is high, that cycle's capture completes the run and the block returns to Idle.
  - Otherwise the timeout counter increments. On reaching `IDLE_TIMEOUT`, set `timeout_o` and return to Idle.
- Capture: write at `resp_count`, then increment. When `resp_count` == RESP_DEPTH, the write is dropped and `overflow_o` is set; the run continues.
- `load_ready_o`, `clear_i` and `start_i` are ignored while `busy_o` is high.
- Stimulus contents persist across runs. Re-start replays the same sequence.

## Timing
- `start_i` sampled high at edge E: `busy_o` is high and `dut_data_o` = stim[0] from E.
- Response captured at edge E+k+1 corresponds to `dut_data_o` = stim[k].
- With N stimuli, Drain begins after edge E+N.
- `done_o` pulses the cycle after the terminating capture edge, with `busy_o` low in that same cycle.
- Minimum run with idle already high on the first drain cycle: N+1 captures, N+1 busy cycles.
- Timeout run: exactly N+`IDLE_TIMEOUT` captures.
- Reset values: `dut_data_o` = 0, `busy_o` = `done_o` = `timeout_o` = `overflow_o` = 0, counts 0, `load_ready_o` = 1 (after reset deassertion), `resp_rd_data_o` = 0. Buffer contents are undefined.
- Reset mid-run: aborts immediately with no `done_o`, and outputs return to reset values.

## Configuration
- `TINY_NN_REPLAY_SIG_EN` defined:
  - Adds output `sig_o` [15:0], a CRC-16-CCITT (poly 0x1021, init 0xFFFF) over every stored response byte, in order. Dropped bytes are excluded.
  - `sig_o` is reinitialised on start and is valid when `done_o` pulses.
- Macro undefined: the port and logic are absent. Behaviour is otherwise identical.

## Structure
- Package `tiny_nn_replay_pkg` holds:
  - state enum `replay_state_e` {ReplayIdle, ReplayPlay, ReplayDrain}
  - CRC polynomial and init constants
- Sub-module `tiny_nn_replay_ram`: single write port, registered read port, parametrised width/depth. It is instantiated twice (stimulus with an internal read port, response with an external read port).

## Test plan
- Load 3 words 0x1234, 0xABCD, 0x0001, start; core echoes low byte with idle high after 2 drain cycles → `dut_data_o` sequence 1234, ABCD, 0001, 0000; 5 responses captured; `done_o` pulses; `timeout_o` = 0.
- Idle never asserts, N=2, `IDLE_TIMEOUT`=100 → `resp_count_o` = 102, `timeout_o` = 1, one `done_o`.
- `RESP_DEPTH`=4, N=6 → `resp_count_o` = 4, `overflow_o` = 1, run still ends on idle.
- Load 64 words into a 64-deep buffer → `load_ready_o` drops after the 64th; a 65th valid is not accepted; `start_i` with `stim_count` 0 → `busy_o` stays low.
- Assert `rst_i` during Play at idx 2 → `dut_data_o` = 0 and `busy_o` = 0 immediately; no `done_o`.
- With `TINY_NN_REPLAY_SIG_EN`, responses 0x31..0x39 ("123456789") → `sig_o` = 0x29B1.
